// File: rtl/scan_config_ctrl.sv
// scan_config_ctrl: sequences the configuration scan chain. It takes host words over a
// valid/ready handshake and shifts them LSB-first onto the chain, one bit per clock.
// VERIFY re-shifts the bitstream and compares each bit with the one leaving the chain.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, mode, abort  start pulse (IDLE only), 0=LOAD 1=VERIFY, cancel operation
//   cfg_data/valid/ready host word handshake, bit 0 shifted first
//   scan_en, scan_in_o  chain shift enable and serial data into the chain head
//   scan_out_i          serial data from the chain tail
//   busy, done          operation active, 1-cycle completion pulse
//   mismatch            sticky VERIFY compare error
//   bit_cnt             bits shifted in the current operation (saturates at CHAIN_LEN)
module scan_config_ctrl #(
   parameter int CHAIN_LEN  = 12,
   parameter int WORD_WIDTH = 4,
   localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  mode,
   input  logic                  abort,
   input  logic [WORD_WIDTH-1:0] cfg_data,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   output logic                  scan_en,
   output logic                  scan_in_o,
   input  logic                  scan_out_i,
   output logic                  busy,
   output logic                  done,
   output logic                  mismatch,
   output logic [CNT_W-1:0]      bit_cnt
);

   localparam int NWORDS = (CHAIN_LEN + WORD_WIDTH - 1) / WORD_WIDTH;
   localparam int WC_W   = $clog2(NWORDS + 1);
   localparam int BC_W   = $clog2(WORD_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      VERIFY,
      DONE
   } state_t;

   state_t                state_q;
   logic [WORD_WIDTH-1:0] buf_q;
   logic [BC_W-1:0]       buf_cnt_q;
   logic [CNT_W-1:0]      bit_cnt_q;
   logic [WC_W-1:0]       wcnt_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  mismatch_q;

   logic shift_en;
   logic room;
   logic take;
   logic last_bit;

   assign shift_en = busy_q && (buf_cnt_q != '0)
                     && (bit_cnt_q < CNT_W'(CHAIN_LEN));

   // The buffer can take a new word when empty, or when its last bit
   // leaves on this edge, which keeps the chain shifting every clock.
   assign room = (buf_cnt_q == '0)
                 || ((buf_cnt_q == BC_W'(1)) && shift_en);

   assign cfg_ready = busy_q && !abort && room
                      && (wcnt_q < WC_W'(NWORDS));

   assign take     = cfg_valid && cfg_ready;
   assign last_bit = shift_en && (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));

   assign scan_en   = shift_en;
   assign scan_in_o = buf_q[0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign mismatch  = mismatch_q;
   assign bit_cnt   = bit_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         buf_q      <= '0;
         buf_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         wcnt_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start && !abort) begin
                  state_q    <= mode ? VERIFY : LOAD;
                  busy_q     <= 1'b1;
                  buf_q      <= '0;
                  buf_cnt_q  <= '0;
                  bit_cnt_q  <= '0;
                  wcnt_q     <= '0;
                  mismatch_q <= 1'b0;
               end
            end
            LOAD, VERIFY: begin
               if (shift_en) begin
                  buf_q     <= buf_q >> 1;
                  buf_cnt_q <= buf_cnt_q - BC_W'(1);
                  bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                  // The tail bit equals the bit loaded at this index last time.
                  if (state_q == VERIFY && scan_out_i != buf_q[0])
                     mismatch_q <= 1'b1;
               end
               if (take) begin
                  buf_q     <= cfg_data;
                  buf_cnt_q <= BC_W'(WORD_WIDTH);
                  wcnt_q    <= wcnt_q + WC_W'(1);
               end
               // Leftover upper bits of a partial last word are dropped here.
               if (abort) begin
                  state_q   <= IDLE;
                  busy_q    <= 1'b0;
                  buf_q     <= '0;
                  buf_cnt_q <= '0;
               end else if (last_bit) begin
                  state_q   <= DONE;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  buf_q     <= '0;
                  buf_cnt_q <= '0;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scan_config_ctrl.sv
// tb_scan_config_ctrl: directed bench for scan_config_ctrl with a FIFO scan
// chain model; runs a 12-bit and a 10-bit chain instance.
module tb_scan_config_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       mode = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] cfg_data = '0;
   logic       cfg_valid = 1'b0;
   logic       sel = 1'b0;

   logic       rdy12, en12, sin12, busy12, dn12, mm12;
   logic [3:0] bc12;
   logic       rdy10, en10, sin10, busy10, dn10, mm10;
   logic [3:0] bc10;

   logic [11:0] chain12 = '0;
   logic [9:0]  chain10 = '0;

   always #5 clk = ~clk;

   scan_config_ctrl #(.CHAIN_LEN(12), .WORD_WIDTH(4)) u12 (
      .clk(clk), .rst(rst), .start(start & ~sel), .mode(mode),
      .abort(abort), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
      .cfg_ready(rdy12), .scan_en(en12), .scan_in_o(sin12),
      .scan_out_i(chain12[0]), .busy(busy12), .done(dn12),
      .mismatch(mm12), .bit_cnt(bc12)
   );

   scan_config_ctrl #(.CHAIN_LEN(10), .WORD_WIDTH(4)) u10 (
      .clk(clk), .rst(rst), .start(start & sel), .mode(mode),
      .abort(abort), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
      .cfg_ready(rdy10), .scan_en(en10), .scan_in_o(sin10),
      .scan_out_i(chain10[0]), .busy(busy10), .done(dn10),
      .mismatch(mm10), .bit_cnt(bc10)
   );

   // Chain model: head receives scan_in, tail (bit 0) is the oldest bit.
   always @(posedge clk) begin
      if (en12) chain12 <= {sin12, chain12[11:1]};
      if (en10) chain10 <= {sin10, chain10[9:1]};
   end

   wire rdy = sel ? rdy10 : rdy12;
   wire en  = sel ? en10  : en12;
   wire sin = sel ? sin10 : sin12;
   wire bsy = sel ? busy10 : busy12;
   wire dn  = sel ? dn10  : dn12;
   wire mm  = sel ? mm10  : mm12;
   wire [3:0] bc = sel ? bc10 : bc12;

   logic        clr = 1'b1;
   int          en_cnt, done_cnt, ncyc, first, last, done_at;
   logic [15:0] seq;
   logic        mm1, got1;

   always @(negedge clk) begin
      if (clr) begin
         en_cnt <= 0; done_cnt <= 0; ncyc <= 0; first <= -1;
         last <= 0; done_at <= -1; seq <= '0; mm1 <= 1'b0; got1 <= 1'b0;
      end else begin
         ncyc <= ncyc + 1;
         if (en) begin
            if (en_cnt < 16) seq[en_cnt] <= sin;
            en_cnt <= en_cnt + 1;
            if (first < 0) first <= ncyc;
            last <= ncyc;
         end
         if (dn) begin
            done_cnt <= done_cnt + 1;
            done_at  <= ncyc;
         end
         if (en_cnt == 1 && !got1) begin
            mm1  <= mm;
            got1 <= 1'b1;
         end
      end
   end

   int errs = 0;
   int checks = 0;

   task automatic chk(input string tag, input int unsigned got,
                      input int unsigned exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic op(input bit s10, input bit m, input logic [15:0] w,
                     input int gap_len, input int poke, output int acc);
      int  cyc;
      int  gap;
      bit  seen;
      bit  hs;
      acc = 0; cyc = 0; gap = 0; seen = 0;
      sel = s10; mode = m; clr = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; clr = 1'b0;
      while (!seen && cyc < 80) begin
         cfg_valid = (acc < 4) && !(acc == 1 && gap < gap_len);
         if (acc == 1 && gap < gap_len) gap++;
         cfg_data = 4'(w >> (4 * acc));
         if (cyc == poke) begin
            start = 1'b1;
            mode  = 1'b1;
         end
         #1;
         hs   = cfg_valid && rdy;
         seen = dn;
         @(posedge clk); #1;
         start = 1'b0;
         if (hs) acc++;
         cyc++;
      end
      cfg_valid = 1'b0;
      if (!seen) chk("op_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   int acc;
   int cyc;
   bit hs;

   initial begin
      #13;
      chk("rst_outs", {rdy12, en12, sin12, busy12, dn12, mm12}, 0);
      chk("rst_bitcnt", bc12, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // T1: back-to-back LOAD of A,5,3 (a fourth word is offered but refused)
      op(0, 0, 16'h735A, 0, -1, acc);
      chk("t1_chain", chain12, 12'h35A);
      chk("t1_seq", seq[11:0], 12'h35A);
      chk("t1_en_cnt", en_cnt, 12);
      chk("t1_span", last - first + 1, 12);
      chk("t1_done_next", done_at, last + 1);
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_words", acc, 3);
      chk("t1_bitcnt", bc12, 12);
      chk("t1_idle", {busy12, rdy12, en12, mm12}, 0);

      // T2: VERIFY same stream, then a corrupted first word
      op(0, 1, 16'h035A, 0, -1, acc);
      chk("t2_mm_ok", mm12, 0);
      chk("t2_chain", chain12, 12'h35A);
      chk("t2_en_cnt", en_cnt, 12);
      chk("t2_done", done_cnt, 1);
      op(0, 1, 16'h035B, 0, -1, acc);
      chk("t2_mm_first", mm1, 1);
      chk("t2_mm_end", mm12, 1);
      chk("t2_bad_en", en_cnt, 12);
      chk("t2_bad_done", done_cnt, 1);

      // T3: host bubble of three cycles after the first word
      op(0, 0, 16'h0A6C, 6, -1, acc);
      chk("t3_chain", chain12, 12'hA6C);
      chk("t3_en_cnt", en_cnt, 12);
      chk("t3_span", last - first + 1, 15);
      chk("t3_bitcnt", bc12, 12);
      chk("t3_done_next", done_at, last + 1);

      // T4: 10-bit chain, last word F only partly shifted
      op(1, 0, 16'h5F96, 0, -1, acc);
      chk("t4_chain", chain10, 10'h396);
      chk("t4_seq", seq[9:0], 10'h396);
      chk("t4_en_cnt", en_cnt, 10);
      chk("t4_words", acc, 3);
      chk("t4_bitcnt", bc10, 10);
      chk("t4_done", done_cnt, 1);

      // T5: abort after 5 bits
      sel = 1'b0; mode = 1'b0; clr = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; clr = 1'b0;
      chk("t5_mm_clr", mm12, 0);
      acc = 0; cyc = 0;
      while (en_cnt < 5 && cyc < 40) begin
         cfg_valid = 1'b1;
         cfg_data  = 4'(16'h035A >> (4 * acc));
         #1;
         hs = cfg_valid && rdy12;
         @(posedge clk); #1;
         if (hs) acc++;
         cyc++;
      end
      chk("t5_reach5", bc12, 5);
      abort = 1'b1;
      #1;
      chk("t5_abort_rdy", rdy12, 0);
      @(posedge clk); #1;
      abort = 1'b0; cfg_valid = 1'b0;
      chk("t5_idle", {busy12, en12}, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("t5_no_done", done_cnt, 0);
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      chk("t5_start_abort", busy12, 0);
      op(0, 0, 16'h035A, 0, 5, acc);
      chk("t5_ign_en", en_cnt, 12);
      chk("t5_ign_chain", chain12, 12'h35A);
      chk("t5_ign_done", done_cnt, 1);
      chk("t5_ign_busy", busy12, 0);

      // T6: asynchronous reset mid-LOAD, then a clean LOAD
      clr = 1'b1; start = 1'b1; mode = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; clr = 1'b0;
      cfg_valid = 1'b1; cfg_data = 4'hF;
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("t6_rst_outs", {rdy12, en12, sin12, busy12, dn12, mm12}, 0);
      chk("t6_rst_bitcnt", bc12, 0);
      cfg_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      op(0, 0, 16'h0C96, 0, -1, acc);
      chk("t6_chain", chain12, 12'hC96);
      chk("t6_bitcnt", bc12, 12);
      chk("t6_done", done_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
